// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA board-RAM scheduler.
package vga_pkg;

   localparam int VGA_ROWS_ACTIVE = 480;

   typedef enum logic {
      IDLE,
      RD_WAIT
   } game_fsm_t;

endpackage

// File: rtl/vga_mem_scheduler_if.sv
// Bundle of VGA timing, renderer, game-logic and board-RAM signals around the scheduler.
interface vga_mem_scheduler_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4,
   parameter int FCNT_W = 16
);
   logic [9:0]        row;
   logic              blank;
   logic              disp_valid;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              disp_dvalid;
   logic              game_req;
   logic              game_we;
   logic [ADDR_W-1:0] game_addr;
   logic [DATA_W-1:0] game_wdata;
   logic              game_gnt;
   logic [DATA_W-1:0] game_rdata;
   logic              game_rvalid;
   logic              swap_req;
   logic              swap_ack;
   logic              frame_start;
   logic [FCNT_W-1:0] frame_count;
   logic              front_bank;
   logic [ADDR_W:0]   mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // blank is informational only, so the scheduler side does not consume it
   modport slave (
      input  row, disp_valid, disp_addr, game_req, game_we, game_addr, game_wdata,
             swap_req, mem_rdata,
      output disp_data, disp_dvalid, game_gnt, game_rdata, game_rvalid, swap_ack,
             frame_start, frame_count, front_bank, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output row, blank, disp_valid, disp_addr, game_req, game_we, game_addr, game_wdata,
             swap_req, mem_rdata,
      input  disp_data, disp_dvalid, game_gnt, game_rdata, game_rvalid, swap_ack,
             frame_start, frame_count, front_bank, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/edge_detect.sv
// Rise/fall pulse generator against a one-cycle delayed copy of the input.
module edge_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise,
   output logic fall
);
   logic sig_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sig_q <= RESET_VAL;
      else       sig_q <= sig;
   end

   assign rise = sig & ~sig_q;
   assign fall = ~sig & sig_q;
endmodule

// File: rtl/simple_counter.sv
// Free-running wrap-around counter with enable and synchronous clear.
module simple_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count
);
   logic [W-1:0] count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    count_reg <= '0;
      else if (clr) count_reg <= '0;
      else if (en)  count_reg <= count_reg + 1'b1;
   end

   assign count = count_reg;
endmodule

// File: rtl/vga_mem_scheduler.sv
// Shares one double-banked board RAM between the renderer (front bank, priority)
// and the game logic (back bank), swapping banks only at the start of vblank.
module vga_mem_scheduler #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4,
   parameter int FCNT_W = 16
) (
   input logic                  clk,
   input logic                  reset,
   vga_mem_scheduler_if.slave   bus
);
   import vga_pkg::*;

   logic              vblank, vblank_rise, vblank_fall;
   logic              grant, swap_fire, frame_start;
   game_fsm_t         state_reg;
   logic              front_bank_reg;
   logic              disp_dvalid_reg;
   logic              game_rvalid_reg;
   logic [DATA_W-1:0] game_rdata_reg;

   assign vblank = (bus.row >= 10'(VGA_ROWS_ACTIVE));

   edge_detect #(.RESET_VAL(1'b1)) u_vblank_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (vblank),
      .rise  (vblank_rise),
      .fall  (vblank_fall)
   );

   // Combinational pulses are masked during reset so they read as 0 like the registers
   assign grant       = ~reset & bus.game_req & ~bus.disp_valid & (state_reg == IDLE);
   assign swap_fire   = ~reset & vblank_rise & bus.swap_req;
   assign frame_start = ~reset & vblank_fall;

   always_comb begin
      bus.mem_addr  = {front_bank_reg, bus.disp_addr};
      bus.mem_we    = 1'b0;
      bus.mem_wdata = bus.game_wdata;
      if (grant) begin
         bus.mem_addr = {~front_bank_reg, bus.game_addr};
         bus.mem_we   = bus.game_we;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         front_bank_reg  <= 1'b0;
         disp_dvalid_reg <= 1'b0;
         game_rvalid_reg <= 1'b0;
         game_rdata_reg  <= '0;
      end else begin
         disp_dvalid_reg <= bus.disp_valid;
         if (swap_fire) front_bank_reg <= ~front_bank_reg;
         case (state_reg)
            IDLE: begin
               game_rvalid_reg <= grant & ~bus.game_we;
               if (grant && !bus.game_we) state_reg <= RD_WAIT;
            end
            RD_WAIT: begin
               game_rvalid_reg <= 1'b0;
               game_rdata_reg  <= bus.mem_rdata;
               state_reg       <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   simple_counter #(.W(FCNT_W)) u_frame_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (frame_start),
      .clr   (1'b0),
      .count (bus.frame_count)
   );

   // RAM data arrives during RD_WAIT; the register keeps it visible afterwards
   assign bus.game_rdata  = (state_reg == RD_WAIT) ? bus.mem_rdata : game_rdata_reg;
   assign bus.game_rvalid = game_rvalid_reg;
   assign bus.game_gnt    = grant;
   assign bus.disp_data   = bus.mem_rdata;
   assign bus.disp_dvalid = disp_dvalid_reg;
   assign bus.swap_ack    = swap_fire;
   assign bus.frame_start = frame_start;
   assign bus.front_bank  = front_bank_reg;
endmodule

// File: tb/tb_vga_mem_scheduler.sv
// Directed self-checking bench for vga_mem_scheduler with a behavioural board RAM.
module tb_vga_mem_scheduler;
   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   vga_mem_scheduler_if #(.ADDR_W(8), .DATA_W(4), .FCNT_W(16)) bus ();
   vga_mem_scheduler_if #(.ADDR_W(8), .DATA_W(4), .FCNT_W(4))  bus2 ();

   vga_mem_scheduler #(.ADDR_W(8), .DATA_W(4), .FCNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Narrow frame counter instance, so counter wrap is reachable in a short run
   vga_mem_scheduler #(.ADDR_W(8), .DATA_W(4), .FCNT_W(4)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   assign bus2.row        = bus.row;
   assign bus2.blank      = 1'b0;
   assign bus2.disp_valid = 1'b0;
   assign bus2.disp_addr  = 8'h00;
   assign bus2.game_req   = 1'b0;
   assign bus2.game_we    = 1'b0;
   assign bus2.game_addr  = 8'h00;
   assign bus2.game_wdata = 4'h0;
   assign bus2.swap_req   = 1'b0;
   assign bus2.mem_rdata  = 4'h0;

   // Board RAM: contents start as ram[a] = a[3:0], read data one cycle after address
   logic [3:0] ram [512];
   logic       ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 512; i++) ram[i] <= 4'(i);
         ram_loaded <= 1'b1;
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset          = 1'b1;
      bus.row        = 10'd500;
      bus.blank      = 1'b1;
      bus.disp_valid = 1'b0;
      bus.disp_addr  = 8'h00;
      bus.game_req   = 1'b1;
      bus.game_we    = 1'b0;
      bus.game_addr  = 8'h00;
      bus.game_wdata = 4'h0;
      bus.swap_req   = 1'b0;
      cyc();
      cyc();
      chk("rst_front_bank", 16'(bus.front_bank), 16'h0);
      chk("rst_frame_count", bus.frame_count, 16'h0);
      chk("rst_swap_ack", 16'(bus.swap_ack), 16'h0);
      chk("rst_frame_start", 16'(bus.frame_start), 16'h0);
      chk("rst_game_gnt", 16'(bus.game_gnt), 16'h0);
      chk("rst_game_rvalid", 16'(bus.game_rvalid), 16'h0);
      chk("rst_disp_dvalid", 16'(bus.disp_dvalid), 16'h0);
      chk("rst_game_rdata", 16'(bus.game_rdata), 16'h0);
      bus.game_req = 1'b0;
      reset        = 1'b0;
      cyc();
      chk("no_spurious_frame_start", 16'(bus.frame_start), 16'h0);

      // Display reads, back to back
      bus.blank      = 1'b0;
      bus.disp_valid = 1'b1;
      bus.disp_addr  = 8'h12;
      #1;
      chk("disp_mem_addr", 16'(bus.mem_addr), 16'h012);
      chk("disp_mem_we", 16'(bus.mem_we), 16'h0);
      cyc();
      bus.disp_addr = 8'h13;
      #1;
      chk("disp_dvalid_1", 16'(bus.disp_dvalid), 16'h1);
      chk("disp_data_1", 16'(bus.disp_data), 16'h2);
      cyc();
      chk("disp_dvalid_2", 16'(bus.disp_dvalid), 16'h1);
      chk("disp_data_2", 16'(bus.disp_data), 16'h3);

      // Game write blocked for 3 display cycles
      bus.disp_addr  = 8'h00;
      bus.game_req   = 1'b1;
      bus.game_we    = 1'b1;
      bus.game_addr  = 8'h05;
      bus.game_wdata = 4'hA;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("wr_blocked_gnt", 16'(bus.game_gnt), 16'h0);
         cyc();
      end
      bus.disp_valid = 1'b0;
      #1;
      chk("wr_gnt", 16'(bus.game_gnt), 16'h1);
      chk("wr_mem_addr", 16'(bus.mem_addr), 16'h105);
      chk("wr_mem_we", 16'(bus.mem_we), 16'h1);
      chk("wr_mem_wdata", 16'(bus.mem_wdata), 16'hA);
      cyc();
      bus.game_req = 1'b0;
      #1;
      chk("wr_ram_105", 16'(ram[9'h105]), 16'hA);
      chk("wr_gnt_drop", 16'(bus.game_gnt), 16'h0);

      // Game read, with a following request held through the rvalid cycle
      bus.game_req = 1'b1;
      bus.game_we  = 1'b0;
      #1;
      chk("rd_gnt", 16'(bus.game_gnt), 16'h1);
      chk("rd_mem_addr", 16'(bus.mem_addr), 16'h105);
      chk("rd_mem_we", 16'(bus.mem_we), 16'h0);
      cyc();
      bus.game_we    = 1'b1;
      bus.game_addr  = 8'h06;
      bus.game_wdata = 4'h3;
      #1;
      chk("rd_rvalid", 16'(bus.game_rvalid), 16'h1);
      chk("rd_rdata", 16'(bus.game_rdata), 16'hA);
      chk("rd_wait_no_gnt", 16'(bus.game_gnt), 16'h0);
      cyc();
      chk("rd_rvalid_drop", 16'(bus.game_rvalid), 16'h0);
      chk("rd_rdata_hold", 16'(bus.game_rdata), 16'hA);
      chk("after_rd_gnt", 16'(bus.game_gnt), 16'h1);
      cyc();
      bus.game_req = 1'b0;

      // Frame boundary: row 524 -> 0
      bus.row = 10'd524;
      #1;
      chk("fs_524", 16'(bus.frame_start), 16'h0);
      cyc();
      bus.row = 10'd0;
      #1;
      chk("fs_pulse", 16'(bus.frame_start), 16'h1);
      chk("fc_before", bus.frame_count, 16'h0);
      cyc();
      chk("fs_once", 16'(bus.frame_start), 16'h0);
      chk("fc_after", bus.frame_count, 16'h1);

      // Swap at row 480, coinciding with a game write grant
      bus.row      = 10'd479;
      bus.swap_req = 1'b1;
      #1;
      chk("swap_ack_479", 16'(bus.swap_ack), 16'h0);
      cyc();
      bus.row        = 10'd480;
      bus.game_req   = 1'b1;
      bus.game_we    = 1'b1;
      bus.game_addr  = 8'h07;
      bus.game_wdata = 4'h9;
      #1;
      chk("swap_ack", 16'(bus.swap_ack), 16'h1);
      chk("swap_front_pre", 16'(bus.front_bank), 16'h0);
      chk("swap_gnt", 16'(bus.game_gnt), 16'h1);
      chk("swap_gnt_addr", 16'(bus.mem_addr), 16'h107);
      cyc();
      bus.game_req = 1'b0;
      #1;
      chk("swap_front_post", 16'(bus.front_bank), 16'h1);
      chk("swap_ack_once", 16'(bus.swap_ack), 16'h0);
      chk("swap_ram_107", 16'(ram[9'h107]), 16'h9);
      bus.game_req   = 1'b1;
      bus.game_wdata = 4'h5;
      #1;
      chk("newback_addr", 16'(bus.mem_addr), 16'h007);
      cyc();
      bus.game_req = 1'b0;
      #1;
      chk("newback_ram_007", 16'(ram[9'h007]), 16'h5);
      bus.disp_valid = 1'b1;
      bus.disp_addr  = 8'h05;
      #1;
      chk("newfront_addr", 16'(bus.mem_addr), 16'h105);
      cyc();
      bus.disp_valid = 1'b0;
      #1;
      chk("newfront_data", 16'(bus.disp_data), 16'hA);

      // No request at the vblank edge, then a mid-vblank request
      bus.swap_req = 1'b0;
      bus.row      = 10'd0;
      cyc();
      bus.row = 10'd480;
      #1;
      chk("noswap_ack", 16'(bus.swap_ack), 16'h0);
      cyc();
      chk("noswap_front", 16'(bus.front_bank), 16'h1);
      bus.row      = 10'd490;
      bus.swap_req = 1'b1;
      #1;
      chk("midvb_ack", 16'(bus.swap_ack), 16'h0);
      cyc();
      chk("midvb_front", 16'(bus.front_bank), 16'h1);
      bus.swap_req = 1'b0;

      // Frame counter wrap on the 4-bit instance (two frames counted so far)
      chk("fc2_before_loop", 16'(bus2.frame_count), 16'h2);
      for (int i = 0; i < 13; i++) begin
         bus.row = 10'd0;
         cyc();
         bus.row = 10'd480;
         cyc();
      end
      chk("fc2_max", 16'(bus2.frame_count), 16'hF);
      bus.row = 10'd0;
      #1;
      chk("fc2_wrap_pulse", 16'(bus2.frame_start), 16'h1);
      cyc();
      chk("fc2_wrapped", 16'(bus2.frame_count), 16'h0);
      chk("fc_16", bus.frame_count, 16'h10);

      // Reset while a read is outstanding
      bus.game_req  = 1'b1;
      bus.game_we   = 1'b0;
      bus.game_addr = 8'h03;
      #1;
      chk("rstrd_gnt", 16'(bus.game_gnt), 16'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("rstrd_gnt_off", 16'(bus.game_gnt), 16'h0);
      chk("rstrd_front", 16'(bus.front_bank), 16'h0);
      chk("rstrd_fc", bus.frame_count, 16'h0);
      chk("rstrd_rdata", 16'(bus.game_rdata), 16'h0);
      chk("rstrd_rvalid", 16'(bus.game_rvalid), 16'h0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("rstrd_rvalid_hold", 16'(bus.game_rvalid), 16'h0);
      end
      bus.game_req = 1'b0;
      bus.row      = 10'd500;
      reset        = 1'b0;
      cyc();
      chk("rstrd_rvalid_after", 16'(bus.game_rvalid), 16'h0);
      chk("rstrd_rdata_after", 16'(bus.game_rdata), 16'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
